// File: rtl/out_display_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : out_display_ctrl_pkg
// Brief  : Shared constants and types for the OUT-port display controller:
//          channel count, blank segment pattern, hex segment codes.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
package out_display_ctrl_pkg;

  localparam int NUM_CHAN = 8;

  typedef logic [15:0] chan_word_t;

  // All segments and decimal point dark (outputs are active-low)
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} codes for hex digits 0..F (dp handled separately)
  localparam logic [6:0] SEG7_0 = 7'h40;
  localparam logic [6:0] SEG7_1 = 7'h79;
  localparam logic [6:0] SEG7_2 = 7'h24;
  localparam logic [6:0] SEG7_3 = 7'h30;
  localparam logic [6:0] SEG7_4 = 7'h19;
  localparam logic [6:0] SEG7_5 = 7'h12;
  localparam logic [6:0] SEG7_6 = 7'h02;
  localparam logic [6:0] SEG7_7 = 7'h78;
  localparam logic [6:0] SEG7_8 = 7'h00;
  localparam logic [6:0] SEG7_9 = 7'h10;
  localparam logic [6:0] SEG7_A = 7'h08;
  localparam logic [6:0] SEG7_B = 7'h03;
  localparam logic [6:0] SEG7_C = 7'h46;
  localparam logic [6:0] SEG7_D = 7'h21;
  localparam logic [6:0] SEG7_E = 7'h06;
  localparam logic [6:0] SEG7_F = 7'h0E;

endpackage
`default_nettype wire

// File: rtl/out_display_ctrl_seg7_decode.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : seg7_decode
// Brief  : Combinational hex nibble to active-low 7-segment {g..a} decoder.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module seg7_decode
  import out_display_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  // Map each hex value onto its segment pattern
  always_comb begin
    segs = SEG7_0;
    case (nibble)
      4'h0: segs = SEG7_0;
      4'h1: segs = SEG7_1;
      4'h2: segs = SEG7_2;
      4'h3: segs = SEG7_3;
      4'h4: segs = SEG7_4;
      4'h5: segs = SEG7_5;
      4'h6: segs = SEG7_6;
      4'h7: segs = SEG7_7;
      4'h8: segs = SEG7_8;
      4'h9: segs = SEG7_9;
      4'hA: segs = SEG7_A;
      4'hB: segs = SEG7_B;
      4'hC: segs = SEG7_C;
      4'hD: segs = SEG7_D;
      4'hE: segs = SEG7_E;
      4'hF: segs = SEG7_F;
      default: segs = SEG7_0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/out_display_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : out_display_ctrl
// Brief  : Captures processor OUT results into an 8-channel bank and scans
//          two channels of the selected page onto an 8-digit 7-seg display.
//          Also keeps sticky per-channel written LEDs and an OUT counter.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module out_display_ctrl
  import out_display_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = 16384,
  parameter int CNT_W    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [15:0]      outval1,
  input  logic [15:0]      outval2,
  input  logic [2:0]       outsel,
  input  logic             outdisplay,
  input  logic [1:0]       page_sel,
  output logic [7:0]       seg,
  output logic [7:0]       an,
  output logic [7:0]       led,
  output logic [CNT_W-1:0] out_count
);

  localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  chan_word_t        chan [NUM_CHAN];
  logic [SCAN_W-1:0] scan_cnt;
  logic [2:0]        digit;
  logic [1:0]        page_q;

  chan_word_t        shown_word;
  logic [3:0]        shown_nibble;
  logic [6:0]        shown_segs;
  logic              dp_n;

  // outval2 is reserved on this port; fold it so it is visibly consumed
  logic unused_outval2;
  assign unused_outval2 = ^outval2;

  // Capture OUT strobes into the bank, latch written flags, count events
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHAN; i++) begin
        chan[i] <= '0;
      end
      led       <= '0;
      out_count <= '0;
    end else if (outdisplay) begin
      chan[outsel] <= outval1;
      led[outsel]  <= 1'b1;
      out_count    <= out_count + 1'b1;
    end
  end

  // Digit-slot divider; page only advances at the frame boundary to avoid tearing
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      digit    <= '0;
      page_q   <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      digit    <= digit + 3'd1;
      if (digit == 3'd7) begin
        page_q <= page_sel;
      end
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Upper four digits show the even channel, lower four the odd channel
  always_comb begin
    shown_word   = digit[2] ? chan[{page_q, 1'b0}] : chan[{page_q, 1'b1}];
    shown_nibble = shown_word[3:0];
    case (digit[1:0])
      2'd0: shown_nibble = shown_word[3:0];
      2'd1: shown_nibble = shown_word[7:4];
      2'd2: shown_nibble = shown_word[11:8];
      2'd3: shown_nibble = shown_word[15:12];
      default: shown_nibble = shown_word[3:0];
    endcase
    dp_n = (digit == 3'd4) ? 1'b0 : 1'b1;
  end

  seg7_decode u_seg7_decode (
    .nibble (shown_nibble),
    .segs   (shown_segs)
  );

  // Register display drive; first cycle of each slot blanks anodes against ghosting
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seg <= SEG_OFF;
      an  <= 8'hFF;
    end else begin
      seg <= {dp_n, shown_segs};
      if (scan_cnt == '0) begin
        an <= 8'hFF;
      end else begin
        an <= ~(8'b1 << digit);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_out_display_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_out_display_ctrl
// Brief  : Scoreboard bench for out_display_ctrl with a cycle-count based
//          reference model of the display scan and channel bank.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_out_display_ctrl;

  localparam int SD = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] outval1 = '0;
  logic [15:0] outval2 = '0;
  logic [2:0]  outsel = '0;
  logic        outdisplay = 1'b0;
  logic [1:0]  page_sel = '0;
  logic [7:0]  seg, an, led, out_count;

  logic [3:0]  dec_in = '0;
  logic [6:0]  dec_out;

  int checks = 0;
  int failures = 0;

  localparam logic [7:0] SEG_TAB [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  out_display_ctrl #(.SCAN_DIV(SD), .CNT_W(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .outval1    (outval1),
    .outval2    (outval2),
    .outsel     (outsel),
    .outdisplay (outdisplay),
    .page_sel   (page_sel),
    .seg        (seg),
    .an         (an),
    .led        (led),
    .out_count  (out_count)
  );

  seg7_decode u_dec (
    .nibble (dec_in),
    .segs   (dec_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] seg;
    logic [7:0] an;
    logic [7:0] led;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q [$];

  // Reference model state: everything derives from edges elapsed since reset
  logic [15:0] m_chan [8];
  logic [7:0]  m_led = '0;
  logic [7:0]  m_cnt = '0;
  int          m_page = 0;
  int          m_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: predict what the outputs hold after each edge, then apply the edge
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) m_chan[i] = '0;
      m_led  = '0;
      m_cnt  = '0;
      m_page = 0;
      m_n    = 0;
      exp_q.delete();
    end else begin
      exp_t e;
      int slot_pos, dig, nib;
      logic [15:0] word;
      logic [7:0] code;
      slot_pos = m_n % SD;
      dig      = (m_n / SD) % 8;
      word     = (dig >= 4) ? m_chan[2*m_page] : m_chan[2*m_page+1];
      nib      = int'((word >> (4 * (dig % 4))) & 16'h000F);
      code     = SEG_TAB[nib];
      e.seg    = {(dig == 4) ? 1'b0 : 1'b1, code[6:0]};
      e.an     = (slot_pos == 0) ? 8'hFF : ~(8'h01 << dig);
      if (outdisplay) begin
        m_chan[outsel] = outval1;
        m_led[outsel]  = 1'b1;
        m_cnt          = m_cnt + 8'd1;
      end
      if (slot_pos == SD - 1 && dig == 7) m_page = int'(page_sel);
      m_n++;
      e.led = m_led;
      e.cnt = m_cnt;
      exp_q.push_back(e);
    end
  end

  // Monitor: compare every registered output update against the scoreboard
  always @(posedge clock) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("seg", 32'(seg), 32'(e.seg));
      chk("an", 32'(an), 32'(e.an));
      chk("led", 32'(led), 32'(e.led));
      chk("out_count", 32'(out_count), 32'(e.cnt));
    end
  end

  task automatic drive(input logic od, input logic [2:0] sel, input logic [15:0] val);
    @(negedge clock);
    outdisplay = od;
    outsel     = sel;
    outval1    = val;
    outval2    = 16'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 3'($urandom), 16'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clock);
    outdisplay = 1'b1;
    outsel     = 3'd5;
    outval1    = 16'hDEAD;
    #2 reset = 1'b1;
    #1;
    chk("rst_seg", 32'(seg), 32'h0000_00FF);
    chk("rst_an", 32'(an), 32'h0000_00FF);
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_count", 32'(out_count), 32'h0);
    repeat (2) @(negedge clock);
    reset      = 1'b0;
    outdisplay = 1'b0;
  endtask

  initial begin
    // Decoder exhaustive
    for (int i = 0; i < 16; i++) begin
      logic [7:0] code;
      dec_in = 4'(i);
      #1;
      code = SEG_TAB[i];
      chk("seg7_decode", 32'(dec_out), 32'(code[6:0]));
    end

    repeat (3) @(negedge clock);
    reset = 1'b0;
    idle(10);

    // Mid-run reset with strobe held
    do_reset();

    // Single OUT onto channel 1, page 0
    page_sel = 2'd0;
    drive(1'b1, 3'd1, 16'h1234);
    idle(2 * 8 * SD);

    // Back-to-back strobes to channel 3, then page 1
    drive(1'b1, 3'd3, 16'hABCD);
    drive(1'b1, 3'd3, 16'h00EF);
    drive(1'b0, 3'd0, 16'h0);
    chk("b2b_count", 32'(out_count), 32'd3);
    chk("b2b_led", 32'(led), 32'h0A);
    page_sel = 2'd1;
    idle(2 * 8 * SD);

    // Page change mid-frame
    idle(3 * SD + 1);
    page_sel = 2'd0;
    idle(SD);
    page_sel = 2'd3;
    idle(2 * 8 * SD);

    // Counter wrap: 256 strobes across all channels
    do_reset();
    for (int i = 0; i < 256; i++) drive(1'b1, 3'(i % 8), 16'($urandom));
    drive(1'b0, 3'd0, 16'h0);
    chk("wrap_count", 32'(out_count), 32'd0);
    chk("wrap_led", 32'(led), 32'hFF);

    // Randomised traffic with occasional page changes and one reset
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 63) == 0) page_sel = 2'($urandom);
      if (i == 700) do_reset();
      drive(1'($urandom_range(0, 2) == 0), 3'($urandom), 16'($urandom));
    end
    idle(4);
    @(negedge clock);
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
